// File: rtl/nfc_command_feature_access_if.sv
// Bundle of the command-side and ACG-side signals of the NAND feature-access engine.
// master = dispatcher/ACG environment, slave = nfc_command_feature_access.
interface nfc_command_feature_access_if #(
    parameter int NumberOfWays  = 4,
    parameter int NumParamBytes = 4
);
    logic [5:0]                   iOpcode;
    logic [7:0]                   iAddress;
    logic [8*NumParamBytes-1:0]   iSetParams;
    logic                         iCMDValid;
    logic                         oCMDReady;
    logic [NumberOfWays-1:0]      iWaySelect;
    logic                         oStart;
    logic                         oLastStep;
    logic [8*NumParamBytes-1:0]   oFeatureData;
    logic                         oFeatureValid;
    logic                         oError;
    logic [7:0]                   oACG_Command;
    logic [2:0]                   oACG_CommandOption;
    logic [7:0]                   iACG_Ready;
    logic [7:0]                   iACG_LastStep;
    logic [NumberOfWays-1:0]      oACG_TargetWay;
    logic [15:0]                  oACG_NumOfData;
    logic                         oACG_CASelect;
    logic [39:0]                  oACG_CAData;
    logic [15:0]                  oACG_WriteData;
    logic                         oACG_WriteLast;
    logic                         oACG_WriteValid;
    logic                         iACG_WriteReady;
    logic [15:0]                  iACG_ReadData;
    logic                         iACG_ReadLast;
    logic                         iACG_ReadValid;
    logic                         oACG_ReadReady;
    logic [NumberOfWays-1:0]      iACG_ReadyBusy;

    modport master (
        output iOpcode, iAddress, iSetParams, iCMDValid, iWaySelect,
               iACG_Ready, iACG_LastStep, iACG_WriteReady, iACG_ReadData,
               iACG_ReadLast, iACG_ReadValid, iACG_ReadyBusy,
        input  oCMDReady, oStart, oLastStep, oFeatureData, oFeatureValid, oError,
               oACG_Command, oACG_CommandOption, oACG_TargetWay, oACG_NumOfData,
               oACG_CASelect, oACG_CAData, oACG_WriteData, oACG_WriteLast,
               oACG_WriteValid, oACG_ReadReady
    );

    modport slave (
        input  iOpcode, iAddress, iSetParams, iCMDValid, iWaySelect,
               iACG_Ready, iACG_LastStep, iACG_WriteReady, iACG_ReadData,
               iACG_ReadLast, iACG_ReadValid, iACG_ReadyBusy,
        output oCMDReady, oStart, oLastStep, oFeatureData, oFeatureValid, oError,
               oACG_Command, oACG_CommandOption, oACG_TargetWay, oACG_NumOfData,
               oACG_CASelect, oACG_CAData, oACG_WriteData, oACG_WriteLast,
               oACG_WriteValid, oACG_ReadReady
    );
endinterface

// File: rtl/nfc_command_feature_access.sv
// GET/SET FEATURES (EEh/EFh) command engine driving ACG primitives and tracking R/B#.
// Optional R/B# watchdog: define NFC_FEATURE_RB_TIMEOUT_EN.
module nfc_command_feature_access #(
    parameter int          NumberOfWays    = 4,
    parameter logic [5:0]  GetCommandID    = 6'b000101,
    parameter logic [5:0]  SetCommandID    = 6'b000110,
    parameter int          NumParamBytes   = 4,
    parameter logic [15:0] RBTimeoutCycles = 16'd4096
) (
    input logic iSystemClock,
    input logic iReset,
    nfc_command_feature_access_if.slave bus
);
    localparam int         DataWidth  = 8 * NumParamBytes;
    localparam logic [3:0] ByteCount  = 4'(NumParamBytes);
    localparam logic [3:0] LastByte   = 4'(NumParamBytes - 1);
    localparam logic [7:0] CmdCA      = 8'h08;
    localparam logic [7:0] CmdDataOut = 8'h04;
    localparam logic [7:0] CmdDataIn  = 8'h02;

    typedef enum logic [3:0] {
        sReset, sReady, sCmdLatch, sCmdIssue, sAddrIssue,
        sDataOut, sWaitRBLow, sWaitRBHigh, sDataIn
    } state_t;

    state_t                  state_reg;
    logic                    cmdReady_reg;
    logic                    isGet_reg;
    logic [7:0]              cmdByte_reg;
    logic [7:0]              address_reg;
    logic [DataWidth-1:0]    params_reg;
    logic [NumberOfWays-1:0] targetWay_reg;
    logic [7:0]              acgCommand_reg;
    logic [15:0]             numOfData_reg;
    logic                    caSelect_reg;
    logic [39:0]             caData_reg;
    logic [3:0]              byteIndex_reg;
    logic                    lastStep_reg;
    logic                    featureValid_reg;
    logic [NumberOfWays-1:0] rbMask_reg;
    logic                    rbSync_reg;
    logic [7:0]              featureByte_reg [NumParamBytes];

    logic                 start;
    logic                 acgReady;
    logic                 writeValid;
    logic                 writeFire;
    logic                 captureBeat;
    logic                 clearFeature;
    logic [DataWidth-1:0] shiftedParams;

    assign start        = bus.iCMDValid &&
                          (bus.iOpcode == GetCommandID || bus.iOpcode == SetCommandID);
    assign acgReady     = &bus.iACG_Ready[6:0];
    assign writeValid   = (state_reg == sDataOut) && acgCommand_reg[2] && (byteIndex_reg < ByteCount);
    assign writeFire    = writeValid && bus.iACG_WriteReady;
    assign captureBeat  = (state_reg == sDataIn) && bus.iACG_ReadValid && (byteIndex_reg < ByteCount);
    assign clearFeature = (state_reg == sCmdLatch) && isGet_reg;
    assign shiftedParams = params_reg >> {byteIndex_reg, 3'b000};

`ifdef NFC_FEATURE_RB_TIMEOUT_EN
    logic [15:0] rbTimer_reg;
    logic        error_reg;
    assign bus.oError = error_reg;
`else
    logic [15:0] unusedTimeout;
    assign unusedTimeout = RBTimeoutCycles;
    assign bus.oError    = 1'b0;
`endif

    always_ff @(posedge iSystemClock) begin
        if (iReset) begin
            state_reg        <= sReset;
            cmdReady_reg     <= 1'b1;
            isGet_reg        <= 1'b0;
            cmdByte_reg      <= 8'h00;
            address_reg      <= 8'h00;
            params_reg       <= '0;
            targetWay_reg    <= '0;
            acgCommand_reg   <= 8'h00;
            numOfData_reg    <= 16'h0000;
            caSelect_reg     <= 1'b1;
            caData_reg       <= 40'h0;
            byteIndex_reg    <= 4'd0;
            lastStep_reg     <= 1'b0;
            featureValid_reg <= 1'b0;
            rbMask_reg       <= '0;
            rbSync_reg       <= 1'b1;
`ifdef NFC_FEATURE_RB_TIMEOUT_EN
            rbTimer_reg      <= 16'd0;
            error_reg        <= 1'b0;
`endif
        end else begin
            lastStep_reg     <= 1'b0;
            featureValid_reg <= 1'b0;
            // R/B# of the selected way: mask the raw pins, then reduce
            rbMask_reg       <= bus.iACG_ReadyBusy & ~targetWay_reg;
            rbSync_reg       <= |rbMask_reg;
`ifdef NFC_FEATURE_RB_TIMEOUT_EN
            error_reg        <= 1'b0;
            if (state_reg == sWaitRBLow || state_reg == sWaitRBHigh)
                rbTimer_reg <= rbTimer_reg + 16'd1;
            else
                rbTimer_reg <= 16'd0;
`endif
            case (state_reg)
                sReset, sReady: begin
                    cmdReady_reg <= 1'b1;
                    state_reg    <= sReady;
                    if (start) begin
                        isGet_reg     <= (bus.iOpcode == GetCommandID);
                        cmdByte_reg   <= (bus.iOpcode == GetCommandID) ? 8'hEE : 8'hEF;
                        address_reg   <= bus.iAddress;
                        params_reg    <= bus.iSetParams;
                        targetWay_reg <= ~bus.iWaySelect;
                        cmdReady_reg  <= 1'b0;
                        state_reg     <= sCmdLatch;
                    end
                end
                sCmdLatch: if (acgReady) state_reg <= sCmdIssue;
                // Each issue state raises its command bit once the ACG is idle and
                // drops it on the cycle after the matching LastStep.
                sCmdIssue: begin
                    if (acgCommand_reg == 8'h00) begin
                        if (acgReady) begin
                            acgCommand_reg <= CmdCA;
                            caSelect_reg   <= 1'b1;
                            caData_reg     <= {cmdByte_reg, 32'h0};
                        end
                    end else if (bus.iACG_LastStep[3]) begin
                        acgCommand_reg <= 8'h00;
                        state_reg      <= sAddrIssue;
                    end
                end
                sAddrIssue: begin
                    if (acgCommand_reg == 8'h00) begin
                        if (acgReady) begin
                            acgCommand_reg <= CmdCA;
                            caSelect_reg   <= 1'b0;
                            caData_reg     <= {address_reg, 32'h0};
                        end
                    end else if (bus.iACG_LastStep[3]) begin
                        acgCommand_reg <= 8'h00;
                        byteIndex_reg  <= 4'd0;
                        state_reg      <= isGet_reg ? sWaitRBLow : sDataOut;
                    end
                end
                sDataOut: begin
                    if (writeFire) byteIndex_reg <= byteIndex_reg + 4'd1;
                    if (acgCommand_reg == 8'h00) begin
                        if (acgReady) begin
                            acgCommand_reg <= CmdDataOut;
                            numOfData_reg  <= 16'(NumParamBytes);
                        end
                    end else if (bus.iACG_LastStep[2]) begin
                        acgCommand_reg <= 8'h00;
                        state_reg      <= sWaitRBLow;
                    end
                end
                sWaitRBLow: if (!rbSync_reg) state_reg <= sWaitRBHigh;
                sWaitRBHigh: begin
                    if (rbSync_reg) begin
                        if (isGet_reg) begin
                            byteIndex_reg <= 4'd0;
                            state_reg     <= sDataIn;
                        end else begin
                            lastStep_reg <= 1'b1;
                            cmdReady_reg <= 1'b1;
                            state_reg    <= sReady;
                        end
                    end
                end
                sDataIn: begin
                    if (captureBeat) byteIndex_reg <= byteIndex_reg + 4'd1;
                    if (acgCommand_reg == 8'h00) begin
                        if (acgReady) begin
                            acgCommand_reg <= CmdDataIn;
                            numOfData_reg  <= 16'(NumParamBytes);
                        end
                    end else if (bus.iACG_LastStep[1]) begin
                        acgCommand_reg   <= 8'h00;
                        lastStep_reg     <= 1'b1;
                        featureValid_reg <= 1'b1;
                        cmdReady_reg     <= 1'b1;
                        state_reg        <= sReady;
                    end
                end
                default: state_reg <= sReady;
            endcase
`ifdef NFC_FEATURE_RB_TIMEOUT_EN
            if ((state_reg == sWaitRBLow || state_reg == sWaitRBHigh) &&
                rbTimer_reg == RBTimeoutCycles - 16'd1) begin
                acgCommand_reg <= 8'h00;
                lastStep_reg   <= 1'b1;
                error_reg      <= 1'b1;
                cmdReady_reg   <= 1'b1;
                state_reg      <= sReady;
            end
`endif
        end
    end

    // Saturating byte capture; beats beyond NumParamBytes never match an index
    for (genvar gi = 0; gi < NumParamBytes; gi++) begin : gFeatureByte
        always_ff @(posedge iSystemClock) begin
            if (iReset || clearFeature)
                featureByte_reg[gi] <= 8'h00;
            else if (captureBeat && byteIndex_reg == 4'(gi))
                featureByte_reg[gi] <= bus.iACG_ReadData[7:0];
        end
        assign bus.oFeatureData[gi*8 +: 8] = featureByte_reg[gi];
    end

    logic unusedBits;
    assign unusedBits = ^{bus.iACG_Ready[7], bus.iACG_LastStep[7:4], bus.iACG_LastStep[0],
                          bus.iACG_ReadData[15:8], bus.iACG_ReadLast};

    assign bus.oCMDReady          = cmdReady_reg;
    assign bus.oStart             = start;
    assign bus.oLastStep          = lastStep_reg;
    assign bus.oFeatureValid      = featureValid_reg;
    assign bus.oACG_Command       = acgCommand_reg;
    assign bus.oACG_CommandOption = 3'b000;
    assign bus.oACG_TargetWay     = targetWay_reg;
    assign bus.oACG_NumOfData     = numOfData_reg;
    assign bus.oACG_CASelect      = caSelect_reg;
    assign bus.oACG_CAData        = caData_reg;
    assign bus.oACG_WriteData     = {8'h00, shiftedParams[7:0]};
    assign bus.oACG_WriteLast     = writeValid && (byteIndex_reg == LastByte);
    assign bus.oACG_WriteValid    = writeValid;
    assign bus.oACG_ReadReady     = (state_reg == sDataIn);
endmodule

// File: tb/tb_nfc_command_feature_access.sv
// Directed bench for nfc_command_feature_access: GET, SET, opcode filter, overrun, reset, watchdog.
module tb_nfc_command_feature_access;
    localparam int         Ways   = 4;
    localparam int         NBytes = 4;
    localparam logic [5:0] GetId  = 6'b000101;
    localparam logic [5:0] SetId  = 6'b000110;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int vectors = 0;
    int miscompares = 0;

    nfc_command_feature_access_if #(.NumberOfWays(Ways), .NumParamBytes(NBytes)) bus ();

    nfc_command_feature_access #(
        .NumberOfWays(Ways), .GetCommandID(GetId), .SetCommandID(SetId),
        .NumParamBytes(NBytes), .RBTimeoutCycles(16'd100)
    ) dut (
        .iSystemClock(clk),
        .iReset(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitCmd(input logic [7:0] want, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (bus.oACG_Command === want) seen = 1'b1;
            else tick();
        end
    endtask

    task automatic pulseLast(input logic [7:0] b);
        bus.iACG_LastStep = b;
        tick();
        bus.iACG_LastStep = 8'h00;
    endtask

    task automatic startCmd(input logic [5:0] op, input logic [7:0] addr,
                            input logic [3:0] way, input logic [31:0] params);
        bus.iOpcode = op; bus.iAddress = addr; bus.iWaySelect = way;
        bus.iSetParams = params; bus.iCMDValid = 1'b1;
        tick();
        bus.iCMDValid = 1'b0;
    endtask

    task automatic caPhases(input logic [7:0] cmdByte, input logic [7:0] addr, input logic [3:0] way);
        bit seen;
        waitCmd(8'h08, seen);
        vectors++;
        if (!seen || bus.oACG_CAData[39:32] !== cmdByte || bus.oACG_CASelect !== 1'b1) begin
            miscompares++;
            $display("FAIL cmd_issue: seen=%0b ca=%h sel=%b, required ca=%h sel=1", seen, bus.oACG_CAData[39:32], bus.oACG_CASelect, cmdByte);
        end
        vectors++;
        if (bus.oACG_TargetWay !== ~way) begin
            miscompares++;
            $display("FAIL target_way: got %b, required %b", bus.oACG_TargetWay, ~way);
        end
        pulseLast(8'h08);
        vectors++;
        if (bus.oACG_Command !== 8'h00) begin
            miscompares++;
            $display("FAIL cmd_drop: got %h, required 00", bus.oACG_Command);
        end
        waitCmd(8'h08, seen);
        vectors++;
        if (!seen || bus.oACG_CAData[39:32] !== addr || bus.oACG_CASelect !== 1'b0) begin
            miscompares++;
            $display("FAIL addr_issue: seen=%0b ca=%h sel=%b, required ca=%h sel=0", seen, bus.oACG_CAData[39:32], bus.oACG_CASelect, addr);
        end
        pulseLast(8'h08);
    endtask

    task automatic doGet(input logic [7:0] addr, input logic [3:0] way, input logic [47:0] beats,
                         input int nbeats, input logic [31:0] expData);
        bit seen;
        startCmd(GetId, addr, way, 32'h0);
        vectors++;
        if (bus.oCMDReady !== 1'b0) begin
            miscompares++;
            $display("FAIL get_cmdready_fall: got %b, required 0", bus.oCMDReady);
        end
        caPhases(8'hEE, addr, way);
        vectors++;
        if (bus.oFeatureData !== 32'h0) begin
            miscompares++;
            $display("FAIL get_clear: got %h, required 00000000", bus.oFeatureData);
        end
        bus.iACG_ReadyBusy = ~way;
        repeat (4) tick();
        bus.iACG_ReadyBusy = 4'hF;
        waitCmd(8'h02, seen);
        vectors++;
        if (!seen || bus.oACG_NumOfData !== 16'd4 || bus.oACG_ReadReady !== 1'b1) begin
            miscompares++;
            $display("FAIL get_datain: seen=%0b num=%0d rr=%b, required num=4 rr=1", seen, bus.oACG_NumOfData, bus.oACG_ReadReady);
        end
        for (int i = 0; i < nbeats; i++) begin
            bus.iACG_ReadData = {8'h00, beats[i*8 +: 8]};
            bus.iACG_ReadValid = 1'b1;
            tick();
        end
        bus.iACG_ReadValid = 1'b0;
        pulseLast(8'h02);
        vectors++;
        if (bus.oLastStep !== 1'b1 || bus.oFeatureValid !== 1'b1 || bus.oError !== 1'b0) begin
            miscompares++;
            $display("FAIL get_done: last=%b valid=%b err=%b, required 1 1 0", bus.oLastStep, bus.oFeatureValid, bus.oError);
        end
        vectors++;
        if (bus.oFeatureData !== expData) begin
            miscompares++;
            $display("FAIL get_data: got %h, required %h", bus.oFeatureData, expData);
        end
        tick();
        vectors++;
        if (bus.oLastStep !== 1'b0 || bus.oFeatureValid !== 1'b0 || bus.oCMDReady !== 1'b1) begin
            miscompares++;
            $display("FAIL get_idle: last=%b valid=%b rdy=%b, required 0 0 1", bus.oLastStep, bus.oFeatureValid, bus.oCMDReady);
        end
        $display("GET addr=%h way=%b beats=%0d data=%h", addr, way, nbeats, bus.oFeatureData);
    endtask

    task automatic doSet(input logic [7:0] addr, input logic [3:0] way, input logic [31:0] params,
                         input logic [31:0] priorData);
        bit seen;
        int n;
        startCmd(SetId, addr, way, params);
        caPhases(8'hEF, addr, way);
        waitCmd(8'h04, seen);
        vectors++;
        if (!seen || bus.oACG_NumOfData !== 16'd4) begin
            miscompares++;
            $display("FAIL set_dataout: seen=%0b num=%0d, required num=4", seen, bus.oACG_NumOfData);
        end
        n = 0;
        for (int cyc = 0; cyc < 40 && n < NBytes; cyc++) begin
            bus.iACG_WriteReady = cyc[0];
            if (bus.oACG_WriteValid && bus.iACG_WriteReady) begin
                vectors++;
                if (bus.oACG_WriteData !== {8'h00, params[n*8 +: 8]} || bus.oACG_WriteLast !== (n == NBytes - 1)) begin
                    miscompares++;
                    $display("FAIL set_beat%0d: data=%h last=%b, required data=%h last=%b", n, bus.oACG_WriteData, bus.oACG_WriteLast, {8'h00, params[n*8 +: 8]}, (n == NBytes - 1));
                end
                n++;
            end
            tick();
        end
        bus.iACG_WriteReady = 1'b0;
        vectors++;
        if (n != NBytes || bus.oACG_WriteValid !== 1'b0) begin
            miscompares++;
            $display("FAIL set_beats: count=%0d valid=%b, required count=4 valid=0", n, bus.oACG_WriteValid);
        end
        pulseLast(8'h04);
        bus.iACG_ReadyBusy = ~way;
        repeat (4) tick();
        vectors++;
        if (bus.oLastStep !== 1'b0 || bus.oCMDReady !== 1'b0) begin
            miscompares++;
            $display("FAIL set_early: last=%b rdy=%b, required 0 0", bus.oLastStep, bus.oCMDReady);
        end
        bus.iACG_ReadyBusy = 4'hF;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (bus.oLastStep === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (!seen || bus.oFeatureValid !== 1'b0 || bus.oFeatureData !== priorData) begin
            miscompares++;
            $display("FAIL set_done: seen=%0b valid=%b data=%h, required valid=0 data=%h", seen, bus.oFeatureValid, bus.oFeatureData, priorData);
        end
        $display("SET addr=%h way=%b params=%h beats=%0d", addr, way, params, n);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        vectors++;
        if (bus.oCMDReady !== 1'b1 || bus.oLastStep !== 1'b0 || bus.oFeatureValid !== 1'b0 || bus.oError !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: rdy=%b last=%b valid=%b err=%b, required 1 0 0 0", bus.oCMDReady, bus.oLastStep, bus.oFeatureValid, bus.oError);
        end
        vectors++;
        if (bus.oACG_Command !== 8'h00 || bus.oACG_CASelect !== 1'b1 || bus.oACG_CAData !== 40'h0 ||
            bus.oACG_TargetWay !== 4'h0 || bus.oFeatureData !== 32'h0 || bus.oACG_WriteValid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_acg: cmd=%h sel=%b ca=%h way=%b fd=%h wv=%b, required 00 1 0 0000 0 0", bus.oACG_Command, bus.oACG_CASelect, bus.oACG_CAData, bus.oACG_TargetWay, bus.oFeatureData, bus.oACG_WriteValid);
        end
        rst = 1'b0;
        tick();
        $display("RESET rdy=%b", bus.oCMDReady);
    endtask

    task automatic test_get();
        doGet(8'h01, 4'b0001, 48'h000000000004, 4, 32'h00000004);
    endtask

    task automatic test_set();
        doSet(8'h10, 4'b0100, 32'h44332211, 32'h00000004);
    endtask

    task automatic test_bad_opcode();
        bus.iOpcode = 6'b000111;
        bus.iCMDValid = 1'b1;
        #1;
        vectors++;
        if (bus.oStart !== 1'b0) begin
            miscompares++;
            $display("FAIL bad_op_start: got %b, required 0", bus.oStart);
        end
        repeat (3) tick();
        vectors++;
        if (bus.oCMDReady !== 1'b1 || bus.oACG_Command !== 8'h00) begin
            miscompares++;
            $display("FAIL bad_op_idle: rdy=%b cmd=%h, required 1 00", bus.oCMDReady, bus.oACG_Command);
        end
        bus.iOpcode = GetId;
        #1;
        vectors++;
        if (bus.oStart !== 1'b1) begin
            miscompares++;
            $display("FAIL good_op_start: got %b, required 1", bus.oStart);
        end
        bus.iCMDValid = 1'b0;
        #1;
        $display("OPCODE 000111 ignored, rdy=%b", bus.oCMDReady);
    endtask

    task automatic test_get_overrun();
        doGet(8'h02, 4'b1000, 48'hFFEEDDCCBBAA, 6, 32'hDDCCBBAA);
    endtask

    task automatic test_reset_mid();
        bit seen;
        startCmd(SetId, 8'h20, 4'b0010, 32'hDEADBEEF);
        caPhases(8'hEF, 8'h20, 4'b0010);
        waitCmd(8'h04, seen);
        bus.iACG_WriteReady = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        bus.iACG_WriteReady = 1'b0;
        vectors++;
        if (!seen || bus.oCMDReady !== 1'b1 || bus.oACG_Command !== 8'h00 || bus.oACG_WriteValid !== 1'b0 ||
            bus.oACG_ReadReady !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_ctl: seen=%0b rdy=%b cmd=%h wv=%b rr=%b, required 1 00 0 0", seen, bus.oCMDReady, bus.oACG_Command, bus.oACG_WriteValid, bus.oACG_ReadReady);
        end
        vectors++;
        if (bus.oACG_CASelect !== 1'b1 || bus.oACG_CAData !== 40'h0 || bus.oACG_TargetWay !== 4'h0 ||
            bus.oACG_NumOfData !== 16'h0 || bus.oFeatureData !== 32'h0) begin
            miscompares++;
            $display("FAIL midreset_acg: sel=%b ca=%h way=%b num=%h fd=%h, required 1 0 0 0 0", bus.oACG_CASelect, bus.oACG_CAData, bus.oACG_TargetWay, bus.oACG_NumOfData, bus.oFeatureData);
        end
        rst = 1'b0;
        tick();
        $display("MIDRESET during DATAOut, rdy=%b", bus.oCMDReady);
    endtask

    task automatic test_timeout();
        bit seen;
        int n;
        startCmd(SetId, 8'h30, 4'b0001, 32'h01020304);
        caPhases(8'hEF, 8'h30, 4'b0001);
        waitCmd(8'h04, seen);
        bus.iACG_WriteReady = 1'b1;
        repeat (4) tick();
        bus.iACG_WriteReady = 1'b0;
        pulseLast(8'h04);
        bus.iACG_ReadyBusy = 4'hF;
        seen = 1'b0;
        n = 0;
`ifdef NFC_FEATURE_RB_TIMEOUT_EN
        while (!seen && n < 1200) begin
            tick();
            n++;
            if (bus.oLastStep === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (!seen || n < 95 || n > 105 || bus.oError !== 1'b1 || bus.oFeatureValid !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_abort: seen=%0b cycles=%0d err=%b valid=%b, required ~100 1 0", seen, n, bus.oError, bus.oFeatureValid);
        end
        tick();
        vectors++;
        if (bus.oCMDReady !== 1'b1 || bus.oError !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_idle: rdy=%b err=%b, required 1 0", bus.oCMDReady, bus.oError);
        end
`else
        for (int i = 0; i < 1000; i++) begin
            tick();
            n++;
            if (bus.oLastStep === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (seen || bus.oCMDReady !== 1'b0 || bus.oError !== 1'b0) begin
            miscompares++;
            $display("FAIL no_timeout: last_seen=%0b rdy=%b err=%b, required 0 0 0", seen, bus.oCMDReady, bus.oError);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
`endif
        $display("TIMEOUT stuck R/B#, cycles=%0d lastStep=%0b", n, seen);
    endtask

    initial begin
        bus.iOpcode = 6'h00; bus.iAddress = 8'h00; bus.iSetParams = '0; bus.iCMDValid = 1'b0;
        bus.iWaySelect = 4'b0001; bus.iACG_Ready = 8'hFF; bus.iACG_LastStep = 8'h00;
        bus.iACG_WriteReady = 1'b0; bus.iACG_ReadData = 16'h0; bus.iACG_ReadLast = 1'b0;
        bus.iACG_ReadValid = 1'b0; bus.iACG_ReadyBusy = 4'hF;
        test_reset();
        test_get();
        test_set();
        test_bad_opcode();
        test_get_overrun();
        test_reset_mid();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "bench timeout");
    end
endmodule

// File: doc/nfc_command_feature_access.md
# nfc_command_feature_access

Parametrised NAND feature-access command engine for both GET FEATURES (EEh) and SET FEATURES (EFh), with a configurable parameter-byte count. It sits between the command dispatcher and the atomic command generator (ACG) array, alongside the other NFC_Command_* blocks. It issues the command, feature address and parameter data through ACG primitives, and tracks R/B# on the selected way. For GET it returns the captured parameter bytes to the host side.

## Interface
Parameters:
- NumberOfWays, 4, number of ways; width of way vectors.
- GetCommandID, 6'b000101, opcode that selects GET FEATURES.
- SetCommandID, 6'b000110, opcode that selects SET FEATURES.
- NumParamBytes, 4, parameter bytes P1..Pn per access (1..8).
- RBTimeoutCycles, 16'd4096, R/B# watchdog limit (used only with macro).

Ports:
- iSystemClock  in  1  clock. Reset is iReset: synchronous, active-high.
- iReset  in  1  synchronous active-high reset.
- iOpcode  in  6  command opcode.
- iAddress  in  8  feature address.
- iSetParams  in  8*NumParamBytes  SET data; P1 occupies [7:0].
- iCMDValid  in  1  command valid.
- oCMDReady  out  1  block idle and accepting a command.
- iWaySelect  in  NumberOfWays  one-hot target way.
- oStart  out  1  combinational: opcode matches Get or Set ID, and iCMDValid is high.
- oLastStep  out  1  one-cycle completion pulse.
- oFeatureData  out  8*NumParamBytes  GET result; P1 occupies [7:0].
- oFeatureValid  out  1  one-cycle pulse, coincident with oLastStep, on GET completion only.
- oError  out  1  watchdog abort flag, coincident with oLastStep.
- oACG_Command  out  8  primitive one-hot: bit3 = CA issue, bit2 = data out, bit1 = data in.
- oACG_CommandOption  out  3  always 3'b000.
- iACG_Ready  in  8  ACG is ready when [6:0] are all ones.
- iACG_LastStep  in  8  per-primitive done.
- oACG_TargetWay  out  NumberOfWays  active-low way select (~iWaySelect).
- oACG_NumOfData  out  16  byte count for data primitives.
- oACG_CASelect  out  1  1 = command cycle, 0 = address/data.
- oACG_CAData  out  40  command or address byte in [39:32].
- oACG_WriteData  out  16  {8'h00, Pk}.
- oACG_WriteLast  out  1  final write beat.
- oACG_WriteValid  out  1  write beat valid.
- iACG_WriteReady  in  1  write beat accepted.
- iACG_ReadData  in  16  read beat; the byte is in [7:0].
- iACG_ReadLast  in  1  final read beat.
- iACG_ReadValid  in  1  read beat valid.
- oACG_ReadReady  out  1  read beat accepted; high throughout DATAIn.
- iACG_ReadyBusy  in  NumberOfWays  raw R/B# per way.

## Operation
- States: RESET → READY → CMDLatch → CMDIssue → ADDRIssue → (SET: DATAOut) → WaitRBLow → WaitRBHigh → (GET: DATAIn) → READY.
- READY: oCMDReady=1. oStart latches the mode, the opcode-derived command byte, iAddress, iSetParams, and ~iWaySelect. A non-matching opcode is ignored.
- CMDIssue: Command=bit3, CASelect=1, CAData[39:32]=EEh (GET) or EFh (SET). The state advances on iACG_LastStep[3].
- ADDRIssue: Command=bit3, CASelect=0, CAData[39:32]=iAddress (latched). The state advances on iACG_LastStep[3].
- DATAOut (SET): Command=bit2 and NumOfData=NumParamBytes.
  - A byte counter drives WriteData={8'h00, P[k]}.
  - WriteLast is asserted at k=NumParamBytes-1.
  - k advances only on WriteValid&WriteReady.
  - The state exits on iACG_LastStep[2].
- WaitRBLow / WaitRBHigh: R/B# of the target way passes through a two-register sync (mask, then OR), the same as all NFC_Command blocks. The FSM waits for 0, then for 1.
- DATAIn (GET): Command=bit1 and NumOfData=NumParamBytes, with ReadReady=1.
  - Each ReadValid writes byte k into oFeatureData. k saturates; extra beats are dropped.
  - On iACG_LastStep[1], the FSM pulses oLastStep and oFeatureValid.
- SET completion: oLastStep pulses on the cycle the synchronised R/B# returns high.
- oFeatureData holds its value until the next GET starts; it is cleared in CMDLatch.
- Command bits drop to 0 in the cycle after the matching LastStep.

## Timing
- Reset values:
  - oCMDReady=1.
  - oLastStep, oFeatureValid, oError, all ACG valid/command outputs = 0.
  - CASelect=1, CAData=0, TargetWay=0, oFeatureData=0.
- Reset asserted mid-operation aborts the transaction. Outputs take their reset values on the next edge, and the ACG handshake is abandoned.
- oCMDReady falls in the cycle after acceptance, which is CMDLatch.
- R/B# observation lags the pins by 2 cycles.
- If iCMDValid is held high during a busy period, it is not accepted until READY is re-entered.

## Configuration
- NFC_FEATURE_RB_TIMEOUT_EN defined:
  - A 16-bit counter runs in WaitRBLow + WaitRBHigh and is cleared on entry to WaitRBLow.
  - At RBTimeoutCycles, the FSM returns to READY and pulses oLastStep with oError=1. oFeatureValid stays 0.
- NFC_FEATURE_RB_TIMEOUT_EN undefined: the FSM waits indefinitely, and oError is tied to 0.

## Test plan
- GET, way 0001, addr 01h. ACG returns 04,00,00,00 → CAData EE then 01. oFeatureData=32'h00000004, oFeatureValid and oLastStep pulse together.
- SET, addr 10h, iSetParams=32'h44332211, with WriteReady toggling every other cycle → data beats 11,22,33,44 in order, WriteLast on 44, then an R/B# low-high cycle, then oLastStep.
- Opcode 6'b000111 with iCMDValid=1 → oStart=0 and the FSM stays in READY.
- GET, ACG sends 6 beats with NumParamBytes=4 → only the first 4 bytes are stored.
- iReset asserted during DATAOut → next cycle oCMDReady=1 and all ACG outputs are at reset values.
- With macro defined and RBTimeoutCycles=100, R/B# stuck high → oError=1 and oLastStep pulse about 100 cycles after WaitRBLow entry. Without the macro, the FSM is still busy after 1000 cycles.
